// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax CAM-subtract / exp-LUT engine.
package softmax_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  localparam int unsigned SUB_OFS_DEF = 50;
  localparam int unsigned LUT_LEN_DEF = 64;
  localparam int unsigned EXP_D_DEF   = 16;

  // Bit idx of a one-hot vector whose hot position is pos; pos < 0 yields no hot bit.
  function automatic logic onehot_bit(input int pos, input int idx);
    return pos == idx;
  endfunction

endpackage

// File: rtl/softmax_exp_lut.sv
// Exp lookup table: register array with one write port and a combinational read port.
module softmax_exp_lut #(
  parameter int unsigned EXP_D = 16,
  parameter int unsigned EW    = 32,
  localparam int unsigned AW   = $clog2(EXP_D)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);

  logic [EW-1:0] mem_q [EXP_D];

  // Contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < EXP_D)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < EXP_D) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/softmax_cam_engine.sv
// Buffers one signed vector, finds its max, then streams x[k]-max as a one-hot match vector
// plus the exp LUT value for it, accumulating a saturating sum of the exp values.
module softmax_cam_engine
  import softmax_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned LUT_LEN = LUT_LEN_DEF,
  parameter int unsigned SUB_OFS = SUB_OFS_DEF,
  parameter int unsigned EXP_D   = EXP_D_DEF,
  parameter int unsigned EW      = 32,
  parameter int unsigned SUM_W   = 32,
  localparam int unsigned IW     = $clog2(N),
  localparam int unsigned AW     = $clog2(EXP_D)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic               lut_we,
  input  logic [AW-1:0]      lut_addr,
  input  logic [EW-1:0]      lut_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LUT_LEN-1:0] out_mv,
  output logic [EW-1:0]      out_exp,
  output logic [IW-1:0]      out_idx,
  output logic               out_uflow,
  output logic               done,
  output logic [SUM_W-1:0]   sum_exp
);

  localparam int unsigned AccW = ((EW > SUM_W) ? EW : SUM_W) + 1;

  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, k_q, k_d;
  logic last_q, last_d;
  logic signed [DW-1:0] max_q, max_d;
  logic [DW-1:0] elem_q [N];
  logic out_valid_q, out_valid_d, out_uflow_q, out_uflow_d;
  logic [LUT_LEN-1:0] out_mv_q, out_mv_d;
  logic [EW-1:0] out_exp_q, out_exp_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  logic in_fire, out_fire, lut_wr, uflow;
  logic signed [DW:0] sub;
  logic [DW:0] neg;
  int pos;
  logic [AW-1:0] lut_raddr;
  logic [EW-1:0] lut_rdata, exp_val;
  logic [LUT_LEN-1:0] mv;
  logic [AccW-1:0] acc;

  assign in_ready  = (state_q == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign lut_wr    = lut_we && (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_mv    = out_mv_q;
  assign out_exp   = out_exp_q;
  assign out_idx   = out_idx_q;
  assign out_uflow = out_uflow_q;
  assign sum_exp   = sum_q;

  softmax_exp_lut #(
    .EXP_D(EXP_D),
    .EW   (EW)
  ) u_lut (
    .clk_i  (clk),
    .we_i   (lut_wr),
    .waddr_i(lut_addr),
    .wdata_i(lut_wdata),
    .raddr_i(lut_raddr),
    .rdata_o(lut_rdata)
  );

  // Difference is taken one bit wider than the data so it can never wrap.
  always_comb begin
    sub       = {elem_q[k_q][DW-1], elem_q[k_q]} - {max_q[DW-1], max_q};
    neg       = -sub;
    pos       = int'(sub) + int'(SUB_OFS);
    uflow     = (pos < 0);
    mv        = '0;
    for (int i = 0; i < int'(LUT_LEN); i++) begin
      mv[i] = onehot_bit(pos, i);
    end
    lut_raddr = AW'(neg);
    exp_val   = (int'(neg) < int'(EXP_D)) ? lut_rdata : '0;
    acc       = AccW'(sum_q) + AccW'(out_exp_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    last_d      = last_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    out_mv_d    = out_mv_q;
    out_exp_d   = out_exp_q;
    out_idx_d   = out_idx_q;
    out_uflow_d = out_uflow_q;
    sum_d       = sum_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        if (in_fire) begin
          if (cnt_q == '0 || $signed(in_data) > max_q) begin
            max_d = $signed(in_data);
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IW'(N - 1)) begin
            state_d = EMIT;
            k_d     = '0;
            last_d  = 1'b0;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          sum_d = (acc > AccW'({SUM_W{1'b1}})) ? '1 : SUM_W'(acc);
          if (out_idx_q == IW'(N - 1)) begin
            state_d = DONE;
          end
        end
        if ((!out_valid_q || out_ready) && !last_q) begin
          out_valid_d = 1'b1;
          out_mv_d    = mv;
          out_exp_d   = exp_val;
          out_idx_d   = k_q;
          out_uflow_d = uflow;
          k_d         = k_q + 1'b1;
          last_d      = (k_q == IW'(N - 1));
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      last_q      <= 1'b0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_mv_q    <= '0;
      out_exp_q   <= '0;
      out_idx_q   <= '0;
      out_uflow_q <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      last_q      <= last_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_mv_q    <= out_mv_d;
      out_exp_q   <= out_exp_d;
      out_idx_q   <= out_idx_d;
      out_uflow_q <= out_uflow_d;
      sum_q       <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      elem_q[cnt_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_softmax_cam_engine.sv
// Self-checking bench for softmax_cam_engine against a vector-level reference model.
module tb_softmax_cam_engine;

  localparam int N = 16, DW = 8, LUT_LEN = 64, SUB_OFS = 50, EXP_D = 16, EW = 32, SUM_W = 32;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, lut_we = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [3:0] lut_addr = '0;
  logic [EW-1:0] lut_wdata = '0;
  logic in_ready, out_valid, out_uflow, done;
  logic [LUT_LEN-1:0] out_mv;
  logic [EW-1:0] out_exp;
  logic [3:0] out_idx;
  logic [SUM_W-1:0] sum_exp;

  softmax_cam_engine dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_mv(out_mv), .out_exp(out_exp),
    .out_idx(out_idx), .out_uflow(out_uflow), .done(done), .sum_exp(sum_exp)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [EW-1:0] lut_model [EXP_D];
  int vec [N];
  logic [LUT_LEN-1:0] exp_mv [N], got_mv [N];
  logic [EW-1:0] exp_ex [N], got_ex [N];
  logic exp_uf [N], got_uf [N];
  int got_idx [N];
  logic [SUM_W-1:0] exp_sum, got_sum;
  int n_got, done_cnt, stall_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: softmax-style subtract of the vector maximum, LUT lookup, saturating sum.
  task automatic model_vector();
    int mx;
    longint s;
    mx = vec[0];
    for (int i = 1; i < N; i++) if (vec[i] > mx) mx = vec[i];
    s = 0;
    for (int k = 0; k < N; k++) begin
      int sub, pos;
      sub = vec[k] - mx;
      pos = sub + SUB_OFS;
      exp_uf[k] = (pos < 0);
      exp_mv[k] = (pos < 0) ? '0 : (LUT_LEN'(1) << pos);
      exp_ex[k] = (-sub < EXP_D) ? lut_model[-sub] : '0;
      s += longint'(exp_ex[k]);
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    end
    exp_sum = s[31:0];
  endtask

  task automatic write_lut(input int a, input logic [EW-1:0] d);
    lut_we = 1'b1;
    lut_addr = 4'(a);
    lut_wdata = d;
    tick();
    lut_we = 1'b0;
    lut_model[a] = d;
  endtask

  // Drives vec through the engine and records every accepted output element.
  // mode: 0 ready always, 1 ready toggles, 2 random ready. abort_at >= 0 asserts reset at that idx.
  task automatic run_vector(input int mode, input bit disturb, input int abort_at);
    logic [LUT_LEN-1:0] pmv;
    logic [EW-1:0] pex;
    logic [3:0] pidx;
    logic puf, prev_stall, r;
    int guard;
    n_got = 0; done_cnt = 0; stall_err = 0; prev_stall = 1'b0; guard = 0;
    pmv = '0; pex = '0; pidx = '0; puf = 1'b0; got_sum = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_data = DW'(vec[i]);
      in_valid = 1'b1;
      if (disturb) begin
        lut_we = 1'b1; lut_addr = 4'd0; lut_wdata = 32'hDEAD_BEEF;
      end
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      tick();
    end
    in_valid = 1'b0;
    lut_we = 1'b0;
    guard = 0;
    while (guard < 400) begin
      if (done) begin
        done_cnt++;
        got_sum = sum_exp;
      end else if (done_cnt > 0) begin
        break;
      end
      if (abort_at >= 0 && out_valid && int'(out_idx) == abort_at) begin
        rst = 1'b0;
        break;
      end
      if (prev_stall && out_valid &&
          (out_mv !== pmv || out_exp !== pex || out_idx !== pidx || out_uflow !== puf)) begin
        stall_err++;
      end
      case (mode)
        0: r = 1'b1;
        1: r = (guard % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (disturb) start = (n_got < 10);
      out_ready = r;
      if (out_valid && r) begin
        if (n_got < N) begin
          got_mv[n_got] = out_mv; got_ex[n_got] = out_exp;
          got_uf[n_got] = out_uflow; got_idx[n_got] = int'(out_idx);
        end
        n_got++;
      end
      prev_stall = out_valid && !r;
      pmv = out_mv; pex = out_exp; pidx = out_idx; puf = out_uflow;
      tick();
      guard++;
    end
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_uflow !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: in_ready=%b out_valid=%b done=%b uflow=%b want all 0",
               in_ready, out_valid, done, out_uflow);
    end
    checks++;
    if (out_mv !== '0 || out_exp !== '0 || out_idx !== '0 || sum_exp !== '0) begin
      errors++;
      $display("FAIL reset data: mv=%h exp=%h idx=%0d sum=%h want all 0",
               out_mv, out_exp, out_idx, sum_exp);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    for (int i = 0; i < EXP_D; i++) write_lut(i, EW'(1) << (15 - i));
    for (int i = 0; i < N; i++) vec[i] = i;
    model_vector();
    run_vector(0, 1'b0, -1);
    checks++;
    if (n_got !== N || done_cnt !== 1) begin
      errors++;
      $display("FAIL ramp count: got %0d elems %0d done want %0d elems 1 done", n_got, done_cnt, N);
    end
    checks++;
    if (got_sum !== 32'h0000_FFFF || got_sum !== exp_sum) begin
      errors++;
      $display("FAIL ramp sum: got %h want %h", got_sum, 32'h0000_FFFF);
    end
    checks++;
    if (got_mv[15] !== (LUT_LEN'(1) << 50) || got_ex[15] !== 32'h8000) begin
      errors++;
      $display("FAIL ramp k15: mv=%h exp=%h want mv bit 50 exp 8000", got_mv[15], got_ex[15]);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k] ||
          got_uf[k] !== exp_uf[k]) begin
        errors++;
        $display("FAIL ramp elem %0d: idx=%0d mv=%h exp=%h uf=%b want idx=%0d mv=%h exp=%h uf=%b",
                 k, got_idx[k], got_mv[k], got_ex[k], got_uf[k], k, exp_mv[k], exp_ex[k], exp_uf[k]);
      end
    end
  endtask

  task automatic test_all_negative();
    for (int i = 0; i < N; i++) vec[i] = -20 + i;
    model_vector();
    run_vector(0, 1'b0, -1);
    checks++;
    if (n_got !== N || done_cnt !== 1 || got_sum !== exp_sum) begin
      errors++;
      $display("FAIL neg summary: elems=%0d done=%0d sum=%h want %0d 1 %h",
               n_got, done_cnt, got_sum, N, exp_sum);
    end
    checks++;
    if (got_mv[0] !== (LUT_LEN'(1) << 35) || got_ex[0] !== 32'd1 ||
        got_mv[15] !== (LUT_LEN'(1) << 50)) begin
      errors++;
      $display("FAIL neg ends: mv0=%h exp0=%h mv15=%h want bit35 1 bit50", got_mv[0], got_ex[0],
               got_mv[15]);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k] ||
          got_uf[k] !== exp_uf[k]) begin
        errors++;
        $display("FAIL neg elem %0d: mv=%h exp=%h uf=%b want mv=%h exp=%h uf=%b",
                 k, got_mv[k], got_ex[k], got_uf[k], exp_mv[k], exp_ex[k], exp_uf[k]);
      end
    end
  endtask

  task automatic test_underflow();
    vec[0] = 100; vec[1] = -100;
    for (int i = 2; i < N; i++) vec[i] = 0;
    model_vector();
    run_vector(0, 1'b0, -1);
    checks++;
    if (got_uf[1] !== 1'b1 || got_mv[1] !== '0 || got_ex[1] !== '0) begin
      errors++;
      $display("FAIL uflow k1: uf=%b mv=%h exp=%h want 1 0 0", got_uf[1], got_mv[1], got_ex[1]);
    end
    checks++;
    if (n_got !== N || got_sum !== exp_sum) begin
      errors++;
      $display("FAIL uflow sum: elems=%0d sum=%h want %0d %h", n_got, got_sum, N, exp_sum);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k] ||
          got_uf[k] !== exp_uf[k]) begin
        errors++;
        $display("FAIL uflow elem %0d: mv=%h exp=%h uf=%b want mv=%h exp=%h uf=%b",
                 k, got_mv[k], got_ex[k], got_uf[k], exp_mv[k], exp_ex[k], exp_uf[k]);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) vec[i] = i;
    model_vector();
    run_vector(1, 1'b0, -1);
    checks++;
    if (stall_err !== 0) begin
      errors++;
      $display("FAIL stall hold: %0d changes while stalled, want 0", stall_err);
    end
    checks++;
    if (n_got !== N || done_cnt !== 1 || got_sum !== exp_sum) begin
      errors++;
      $display("FAIL stall summary: elems=%0d done=%0d sum=%h want %0d 1 %h",
               n_got, done_cnt, got_sum, N, exp_sum);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k]) begin
        errors++;
        $display("FAIL stall elem %0d: idx=%0d mv=%h exp=%h want idx=%0d mv=%h exp=%h",
                 k, got_idx[k], got_mv[k], got_ex[k], k, exp_mv[k], exp_ex[k]);
      end
    end
  endtask

  // Random LUTs and vectors; the last two LUTs are large enough to force saturation.
  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < EXP_D; i++) begin
        write_lut(i, (it >= 4) ? (32'hC000_0000 | $urandom) : EW'($urandom_range(0, 65535)));
      end
      for (int i = 0; i < N; i++) begin
        vec[i] = (it == 5) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 40)) - 20;
      end
      model_vector();
      run_vector(2, 1'b0, -1);
      checks++;
      if (n_got !== N || done_cnt !== 1 || got_sum !== exp_sum || stall_err !== 0) begin
        errors++;
        $display("FAIL rand%0d summary: elems=%0d done=%0d sum=%h stall=%0d want %0d 1 %h 0",
                 it, n_got, done_cnt, got_sum, stall_err, N, exp_sum);
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k] ||
            got_uf[k] !== exp_uf[k]) begin
          errors++;
          $display("FAIL rand%0d elem %0d: mv=%h exp=%h uf=%b want mv=%h exp=%h uf=%b",
                   it, k, got_mv[k], got_ex[k], got_uf[k], exp_mv[k], exp_ex[k], exp_uf[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    for (int i = 0; i < N; i++) vec[i] = 3 * i - 30;
    run_vector(0, 1'b0, 7);
    #2;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || out_mv !== '0 ||
        out_exp !== '0 || out_idx !== '0 || sum_exp !== '0) begin
      errors++;
      $display("FAIL abort clear: valid=%b done=%b rdy=%b mv=%h exp=%h idx=%0d sum=%h want all 0",
               out_valid, done, in_ready, out_mv, out_exp, out_idx, sum_exp);
    end
    tick();
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort done: %0d done cycles want 0", dones);
    end
    model_vector();
    run_vector(0, 1'b0, -1);
    checks++;
    if (n_got !== N || done_cnt !== 1 || got_sum !== exp_sum) begin
      errors++;
      $display("FAIL restart summary: elems=%0d done=%0d sum=%h want %0d 1 %h",
               n_got, done_cnt, got_sum, N, exp_sum);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k]) begin
        errors++;
        $display("FAIL restart elem %0d: mv=%h exp=%h want mv=%h exp=%h",
                 k, got_mv[k], got_ex[k], exp_mv[k], exp_ex[k]);
      end
    end
  endtask

  task automatic test_ignored();
    int busy;
    for (int i = 0; i < N; i++) vec[i] = (i % 5) - 2;
    model_vector();
    run_vector(0, 1'b1, -1);
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      if (in_ready || out_valid) busy++;
      tick();
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL ignored start: engine busy %0d cycles after done want 0", busy);
    end
    checks++;
    if (n_got !== N || done_cnt !== 1 || got_sum !== exp_sum) begin
      errors++;
      $display("FAIL ignored summary: elems=%0d done=%0d sum=%h want %0d 1 %h",
               n_got, done_cnt, got_sum, N, exp_sum);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (got_idx[k] !== k || got_mv[k] !== exp_mv[k] || got_ex[k] !== exp_ex[k]) begin
        errors++;
        $display("FAIL ignored elem %0d: mv=%h exp=%h want mv=%h exp=%h",
                 k, got_mv[k], got_ex[k], exp_mv[k], exp_ex[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < EXP_D; i++) lut_model[i] = '0;
    test_reset();
    test_ramp();
    test_all_negative();
    test_underflow();
    test_stall();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
